// File: rtl/lisa_rx_pkg.sv
// Shared types and default sizing for the LISA receive controller.
package lisa_rx_pkg;

    localparam int unsigned DIV_W_DEF = 16;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/lisa_rx_fifo.sv
// First-word fall-through byte FIFO; a push into a full FIFO is accepted only when
// a pop frees a slot in the same cycle.
module lisa_rx_fifo
    import lisa_rx_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisa_rx_ctrl.sv
// Baud reference generator plus a drain FSM that moves bytes from the 8N1 receiver
// into a small FIFO, flagging any byte lost to a full FIFO.
module lisa_rx_ctrl
    import lisa_rx_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en,
    input  logic [DIV_W-1:0]         cfg_div,
    output logic                     baud_ref,
    input  logic [7:0]               rx_d,
    input  logic                     rx_avail,
    output logic                     rx_rd,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    logic [DIV_W-1:0] w_eff_div;
    logic [DIV_W-1:0] r_baud_cnt;
    logic             r_baud_ref;

    rx_state_e        r_state;
    rx_state_e        w_state_d;
    logic             w_push;
    logic             w_drop;
    logic             w_rx_rd_d;
    logic             r_rx_rd;
    logic             r_overflow;

    // A zero divisor would stall the counter at zero; treat it as one.
    assign w_eff_div = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= w_eff_div;
            r_baud_ref <= 1'b0;
        end else if (!cfg_en) begin
            r_baud_cnt <= w_eff_div;
            r_baud_ref <= 1'b0;
        end else if (r_baud_cnt == '0) begin
            r_baud_cnt <= w_eff_div;
            r_baud_ref <= 1'b1;
        end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
            r_baud_ref <= 1'b0;
        end
    end

    assign baud_ref = r_baud_ref;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rx_rd <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_rx_rd <= w_rx_rd_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (rx_avail) w_state_d = ACK;
            ACK:     w_state_d = WAIT;
            WAIT:    if (!rx_avail) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // rx_rd is registered from the next state so it is high exactly while in ACK.
    always_comb begin
        w_push    = 1'b0;
        w_rx_rd_d = 1'b0;
        if (r_state == IDLE && rx_avail) begin
            w_push = 1'b1;
        end
        if (w_state_d == ACK) begin
            w_rx_rd_d = 1'b1;
        end
    end

    assign rx_rd  = r_rx_rd;
    assign w_drop = w_push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

    lisa_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (pop),
        .din   (rx_d),
        .dout  (dout),
        .count (count),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_lisa_rx_ctrl.sv
// Bench for lisa_rx_ctrl: baud timing, a table of drain/FIFO vectors, reset during ACK,
// and randomized traffic against a queue-based reference model.
module tb_lisa_rx_ctrl;
    import lisa_rx_pkg::*;

    localparam int DIV_W = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             cfg_en;
    logic [DIV_W-1:0] cfg_div;
    logic             baud_ref;
    logic [7:0]       rx_d;
    logic             rx_avail;
    logic             rx_rd;
    logic             pop;
    logic [7:0]       dout;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    lisa_rx_ctrl #(
        .DIV_W (DIV_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_en   (cfg_en),
        .cfg_div  (cfg_div),
        .baud_ref (baud_ref),
        .rx_d     (rx_d),
        .rx_avail (rx_avail),
        .rx_rd    (rx_rd),
        .pop      (pop),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input bit erd, input int ecnt, input bit eovf,
                            input logic [7:0] edout);
        chk({tag, ".rx_rd"}, 32'(rx_rd), 32'(erd));
        chk({tag, ".count"}, 32'(count), ecnt);
        chk({tag, ".empty"}, 32'(empty), 32'(ecnt == 0));
        chk({tag, ".full"}, 32'(full), 32'(ecnt == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eovf));
        if (ecnt > 0) chk({tag, ".dout"}, 32'(dout), 32'(edout));
    endtask

    // Run with a fixed config and check pulse count and spacing over eight periods.
    task automatic baud_check(input string tag, input bit en, input int div);
        int per;
        int last;
        int pulses;
        int bad_gap;
        per     = ((div == 0) ? 1 : div) + 1;
        last    = -1;
        pulses  = 0;
        bad_gap = 0;
        cfg_en  = en;
        cfg_div = DIV_W'(div);
        repeat (40) tick();
        for (int i = 0; i < 8 * per; i++) begin
            tick();
            if (baud_ref === 1'b1) begin
                pulses++;
                if (last >= 0 && (i - last) != per) bad_gap++;
                last = i;
            end
        end
        chk({tag, ".pulses"}, pulses, en ? 8 : 0);
        chk({tag, ".bad_gaps"}, bad_gap, 0);
    endtask

    typedef struct {
        bit         avail;
        logic [7:0] d;
        bit         pop;
        bit         clr;
        bit         erd;
        int         ecnt;
        bit         eovf;
        logic [7:0] edout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit avail, input logic [7:0] d, input bit p, input bit clr,
                                input bit erd, input int ecnt, input bit eovf,
                                input logic [7:0] edout);
        vec_t v;
        v.avail = avail; v.d = d; v.pop = p; v.clr = clr;
        v.erd = erd; v.ecnt = ecnt; v.eovf = eovf; v.edout = edout;
        vecs.push_back(v);
    endfunction

    // Receiver presents a byte, holds it through ACK, then drops rx_avail.
    function automatic void add_byte(input logic [7:0] d, input int ecnt, input bit eovf,
                                     input logic [7:0] head);
        add(1'b1, d, 1'b0, 1'b0, 1'b1, ecnt, eovf, head);
        add(1'b1, d, 1'b0, 1'b0, 1'b0, ecnt, eovf, head);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ecnt, eovf, head);
    endfunction

    // Reference model state for the random phase
    logic [7:0] mq[$];
    bit         m_ovf;

    initial begin
        int ticks;
        bit av, av_prev, seen, cap, popped, was_full, drop;
        int gap, hold, waitc;
        logic [7:0] dcur;

        rst = 1'b1; cfg_en = 1'b1; cfg_div = DIV_W'(3);
        rx_d = 8'h00; rx_avail = 1'b0; pop = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        chk("reset.baud_ref", 32'(baud_ref), 0);
        chk_outs("reset", 1'b0, 0, 1'b0, 8'h00);

        // Counter restarts from the effective divisor: first pulse on the 4th edge.
        rst   = 1'b0;
        ticks = 0;
        do begin
            tick();
            ticks++;
        end while (baud_ref !== 1'b1 && ticks < 20);
        chk("reset.first_baud_edge", ticks, 4);

        baud_check("baud_div3", 1'b1, 3);
        baud_check("baud_div0", 1'b1, 0);
        baud_check("baud_div6", 1'b1, 6);
        cfg_en = 1'b0;
        tick();
        chk("baud_off.next_cycle", 32'(baud_ref), 0);
        baud_check("baud_off", 1'b0, 3);
        cfg_en = 1'b1; cfg_div = DIV_W'(3);

        // Single byte
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1, 1'b0, 8'hA5);
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        // FIFO order
        add_byte(8'h01, 1, 1'b0, 8'h01);
        add_byte(8'h02, 2, 1'b0, 8'h01);
        add_byte(8'h03, 3, 1'b0, 8'h01);
        add_byte(8'h04, 4, 1'b0, 8'h01);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3, 1'b0, 8'h02);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b0, 8'h03);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h04);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        // Overflow, clear, and drop colliding with clear
        add_byte(8'h11, 1, 1'b0, 8'h11);
        add_byte(8'h22, 2, 1'b0, 8'h11);
        add_byte(8'h33, 3, 1'b0, 8'h11);
        add_byte(8'h44, 4, 1'b0, 8'h11);
        add_byte(8'h55, 4, 1'b1, 8'h11);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, 8'h11);
        add(1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 4, 1'b1, 8'h11);
        add(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 4, 1'b1, 8'h11);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4, 1'b1, 8'h11);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, 8'h11);
        // Push and pop together while full
        add(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 4, 1'b0, 8'h22);
        add(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h22);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h22);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3, 1'b0, 8'h33);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b0, 8'h44);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h77);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00);

        foreach (vecs[i]) begin
            rx_avail = vecs[i].avail;
            rx_d     = vecs[i].d;
            pop      = vecs[i].pop;
            ovf_clr  = vecs[i].clr;
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].erd, vecs[i].ecnt, vecs[i].eovf,
                     vecs[i].edout);
        end
        rx_avail = 1'b0; pop = 1'b0; ovf_clr = 1'b0;

        // Reset asserted while in ACK
        rx_avail = 1'b1; rx_d = 8'h9A;
        tick();
        chk_outs("rst_ack.pre", 1'b1, 1, 1'b0, 8'h9A);
        rst = 1'b1;
        tick();
        chk_outs("rst_ack.in_reset", 1'b0, 0, 1'b0, 8'h00);
        chk("rst_ack.baud_ref", 32'(baud_ref), 0);
        rst = 1'b0;
        tick();
        chk_outs("rst_ack.recapture", 1'b1, 1, 1'b0, 8'h9A);
        rx_avail = 1'b0;
        tick(); tick();
        pop = 1'b1;
        tick();
        chk_outs("rst_ack.pop", 1'b0, 0, 1'b0, 8'h00);
        tick();
        chk_outs("rst_ack.pop_empty", 1'b0, 0, 1'b0, 8'h00);
        pop = 1'b0;

        // Randomized traffic from a well-behaved receiver
        mq.delete();
        m_ovf = 1'b0;
        av = 1'b0; av_prev = 1'b0; seen = 1'b0;
        gap = 1; hold = 0; waitc = 0; dcur = 8'h00;
        for (int i = 0; i < 500; i++) begin
            pop      = ($urandom_range(0, (i < 250) ? 7 : 1) == 0);
            ovf_clr  = ($urandom_range(0, 15) == 0);
            rx_avail = av;
            rx_d     = dcur;

            cap      = av && !av_prev;
            was_full = (mq.size() == DEPTH);
            popped   = 1'b0;
            drop     = 1'b0;
            if (pop && mq.size() > 0) begin
                void'(mq.pop_front());
                popped = 1'b1;
            end
            if (cap) begin
                if (was_full && !popped) drop = 1'b1;
                else mq.push_back(dcur);
            end
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            av_prev = av;

            tick();
            chk_outs($sformatf("rand%0d", i), cap, mq.size(), m_ovf,
                     (mq.size() > 0) ? mq[0] : 8'h00);

            if (av) begin
                if (!seen) begin
                    waitc++;
                    if (rx_rd === 1'b1) begin
                        seen = 1'b1;
                        hold = $urandom_range(0, 2);
                    end else if (waitc > 4) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rand%0d.rx_rd_timeout: got no pulse required one", i);
                        seen = 1'b1;
                        hold = 0;
                    end
                end
                if (seen) begin
                    if (hold == 0) begin
                        av  = 1'b0;
                        gap = $urandom_range(1, 3);
                    end else begin
                        hold--;
                    end
                end
            end else if (gap == 0) begin
                av    = 1'b1;
                dcur  = 8'($urandom_range(0, 255));
                seen  = 1'b0;
                waitc = 0;
            end else begin
                gap--;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lisa_rx_ctrl.md
LISA_RX_CTRL -- requirements
Module: lisa_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, giving the width of the baud divisor.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count; it must be a power of two and at least 2.
REQ-003 clk  in  1  system clock; single clock domain; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 cfg_en  in  1  1 = baud generator runs; 0 = baud generator held.
REQ-006 cfg_div  in  DIV_W  baud_ref period minus one, in clk cycles.
REQ-007 baud_ref  out  1  16x oversample reference to the 8N1 receiver; registered.
REQ-008 rx_d  in  8  receiver parallel data.
REQ-009 rx_avail  in  1  receiver data-available flag.
REQ-010 rx_rd  out  1  receiver read strobe; registered.
REQ-011 pop  in  1  host removes the FIFO head this cycle.
REQ-012 dout  out  8  FIFO head; first-word fall-through; don't-care when empty.
REQ-013 empty  out  1  FIFO holds 0 entries.
REQ-014 full  out  1  FIFO holds DEPTH entries.
REQ-015 count  out  log2(DEPTH)+1  number of FIFO entries.
REQ-016 overflow  out  1  sticky flag: a byte was dropped.
REQ-017 ovf_clr  in  1  clears overflow.

Function
REQ-018 Baud counter SHALL use an effective divisor of max(cfg_div,1); cfg_div=0 SHALL behave as 1.
REQ-019 When cfg_en=1, the counter SHALL decrement each cycle; on reaching 0 it SHALL reload the effective divisor, and baud_ref SHALL be 1 for exactly the following cycle.
REQ-020 With cfg_en=1, baud_ref SHALL therefore pulse once every effective_divisor+1 cycles, high for one cycle each time.
REQ-021 When cfg_en=0, the counter SHALL hold at the effective divisor and baud_ref SHALL be 0 from the next cycle.
REQ-022 A change to cfg_div SHALL take effect at the next reload.
REQ-023 The drain FSM SHALL have three states: IDLE, ACK and WAIT.
REQ-024 FSM in IDLE: when rx_avail=1, capture rx_d at that edge and move to ACK.
REQ-025 FSM in ACK: rx_rd=1 for exactly one cycle, then unconditionally move to WAIT.
REQ-026 FSM in WAIT: rx_rd=0; move to IDLE on the first cycle rx_avail=0.
REQ-027 rx_rd SHALL be 1 only in ACK, so it rises on IDLE->ACK and the receiver sees one rising edge per byte.
REQ-028 A byte captured in IDLE SHALL be written to the FIFO at the same edge, and count SHALL reflect it in the following cycle.
REQ-029 If the FIFO is full at capture, and no pop occurs that cycle, the byte SHALL be discarded, overflow SHALL be set, and the FSM SHALL still go through ACK/WAIT.
REQ-030 A push and a pop in the same cycle SHALL leave count unchanged, including when the FIFO is full; in that case the byte is not dropped.
REQ-031 pop while empty SHALL be ignored.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH.
REQ-033 FIFO order SHALL be first-in first-out.
REQ-034 If ovf_clr and a new drop occur in the same cycle, overflow SHALL end up 1 (set wins).
REQ-035 The FSM SHALL run independently of cfg_en.

Reset
REQ-036 While rst=1, the following SHALL hold from the next edge: baud_ref=0, rx_rd=0, FSM=IDLE, counter=effective divisor, count=0, empty=1, full=0, overflow=0, FIFO pointers=0.
REQ-037 Reset asserted mid-ACK SHALL drop rx_rd the next cycle and discard FIFO contents.
REQ-038 FIFO storage SHALL need no reset.

Structure
REQ-039 Package lisa_rx_pkg SHALL hold the FSM state enum (IDLE, ACK, WAIT) and the default DIV_W/DEPTH constants.
REQ-040 The FIFO SHALL be a sub-module lisa_rx_fifo with push, pop, din, dout, count, empty and full ports.
REQ-041 The baud counter and drain FSM SHALL sit in lisa_rx_ctrl.

Verification
REQ-042 Baud timing: cfg_en=1, cfg_div=3 -> baud_ref high 1 cycle every 4 cycles; cfg_div=0 -> every 2 cycles; cfg_en=0 -> baud_ref stays 0.
REQ-043 Single byte: rx_avail=1, rx_d=0xA5, and rx_avail drops 2 cycles after rx_rd rises -> one rx_rd pulse of 1 cycle, count=1, dout=0xA5, FSM back in IDLE.
REQ-044 FIFO order: 4 bytes 0x01..0x04 -> full=1, count=4; 4 pops return 0x01,0x02,0x03,0x04, then empty=1.
REQ-045 Overflow: FIFO full, 5th byte 0x55 arrives with no pop -> byte dropped, overflow=1, rx_rd still pulses; ovf_clr -> overflow=0; a repeat drop with ovf_clr in the same cycle -> overflow=1.
REQ-046 Full FIFO, push of 0x77 with pop in the same cycle -> count stays 4, overflow stays 0, 0x77 is read last.
REQ-047 rst pulsed during ACK -> next cycle rx_rd=0, count=0, FSM=IDLE; pop on empty -> count stays 0.
